// File: rtl/vga_plot_arbiter.sv
// rtl/vga_plot_arbiter.sv - round-robin arbiter sharing the VGA adapter pixel port between drawing engines
module vga_plot_arbiter #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   err,
  output logic [NREQ-1:0]   eng_start,
  input  logic [NREQ-1:0]   eng_done,
  input  logic [8*NREQ-1:0] eng_x,
  input  logic [7*NREQ-1:0] eng_y,
  input  logic [3*NREQ-1:0] eng_colour,
  input  logic [NREQ-1:0]   eng_plot,
  output logic [7:0]        vga_x,
  output logic [6:0]        vga_y,
  output logic [2:0]        vga_colour,
  output logic              vga_plot,
  output logic              busy,
  output logic [2:0]        grant_id
);

  localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  // Counter value seen in the last allowed RUN cycle; unused when the timeout is disabled
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RELEASE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        grant_id_q, grant_id_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   eng_start_q, eng_start_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [NREQ-1:0]   err_q, err_d;
  logic [7:0]        vga_x_q, vga_x_d;
  logic [6:0]        vga_y_q, vga_y_d;
  logic [2:0]        vga_colour_q, vga_colour_d;
  logic              vga_plot_q, vga_plot_d;

  logic [NREQ-1:0]   gnt_oh;
  logic [7:0]        sel_x;
  logic [6:0]        sel_y;
  logic [2:0]        sel_colour;
  logic              sel_plot;
  logic              sel_done;
  logic              win_found;
  logic [2:0]        win_id;
  logic [NREQ-1:0]   win_oh;

  // Pick out the granted engine's signals; everything from other engines is dropped here
  always_comb begin
    gnt_oh     = '0;
    sel_x      = '0;
    sel_y      = '0;
    sel_colour = '0;
    sel_plot   = 1'b0;
    sel_done   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id_q == 3'(i)) begin
        gnt_oh[i]  = 1'b1;
        sel_x      = eng_x[8*i +: 8];
        sel_y      = eng_y[7*i +: 7];
        sel_colour = eng_colour[3*i +: 3];
        sel_plot   = eng_plot[i];
        sel_done   = eng_done[i];
      end
    end
  end

  // Round-robin search: first requester after the last winner, wrapping around
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_oh    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!win_found && req[i] && (i == (int'(ptr_q) + k) % NREQ)) begin
          win_found = 1'b1;
          win_id    = 3'(i);
          win_oh[i] = 1'b1;
        end
      end
    end
  end

  // Job sequencing and pixel mux next-state
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    eng_start_d  = eng_start_q;
    ack_d        = '0;
    err_d        = '0;
    vga_x_d      = sel_x;
    vga_y_d      = sel_y;
    vga_colour_d = sel_colour;
    vga_plot_d   = (state_q == S_RUN) && sel_plot;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d     = S_RUN;
          grant_id_d  = win_id;
          ptr_d       = win_id;
          cnt_d       = '0;
          eng_start_d = win_oh;
        end
      end
      S_RUN: begin
        eng_start_d = gnt_oh;
        if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
        // A done arriving in the same cycle as the timeout is a normal completion
        if (sel_done) begin
          state_d     = S_RELEASE;
          eng_start_d = '0;
          ack_d       = gnt_oh;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d     = S_RELEASE;
          eng_start_d = '0;
          ack_d       = gnt_oh;
          err_d       = gnt_oh;
        end
      end
      S_RELEASE: begin
        if (!sel_done) state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        eng_start_d = '0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_id_q   <= 3'(NREQ - 1);
      ptr_q        <= 3'(NREQ - 1);
      cnt_q        <= '0;
      eng_start_q  <= '0;
      ack_q        <= '0;
      err_q        <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      eng_start_q  <= eng_start_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
    end
  end

  assign ack        = ack_q;
  assign err        = err_q;
  assign eng_start  = eng_start_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign busy       = (state_q != S_IDLE);
  assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb/tb_vga_plot_arbiter.sv - randomized engines/requesters against a job-level reference model
module tb_vga_plot_arbiter;

  localparam int NREQ = 3;
  localparam int TO   = 16;
  localparam int NCYC = 4000;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   err;
  logic [NREQ-1:0]   eng_start;
  logic [NREQ-1:0]   eng_done;
  logic [8*NREQ-1:0] eng_x;
  logic [7*NREQ-1:0] eng_y;
  logic [3*NREQ-1:0] eng_colour;
  logic [NREQ-1:0]   eng_plot;
  logic [7:0]        vga_x;
  logic [6:0]        vga_y;
  logic [2:0]        vga_colour;
  logic              vga_plot;
  logic              busy;
  logic [2:0]        grant_id;

  vga_plot_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .err(err),
    .eng_start(eng_start), .eng_done(eng_done), .eng_x(eng_x), .eng_y(eng_y),
    .eng_colour(eng_colour), .eng_plot(eng_plot), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: job phase (0 idle, 1 running, 2 waiting for done to drop)
  int m_phase, m_g, m_last, m_run;
  logic [NREQ-1:0] e_start, e_ack, e_err;
  logic [7:0] e_x;
  logic [6:0] e_y;
  logic [2:0] e_c;
  logic       e_plot;

  // Behavioural engines
  int ecnt[NREQ];
  int lat[NREQ];
  int hold[NREQ];
  logic [NREQ-1:0] edone;
  int grants_seen;
  int timeouts_seen;

  task automatic model_step();
    int w;
    if (rst) begin
      m_phase = 0; m_g = NREQ - 1; m_last = NREQ - 1; m_run = 0;
      e_start = '0; e_ack = '0; e_err = '0;
      e_x = '0; e_y = '0; e_c = '0; e_plot = 1'b0;
      return;
    end
    e_x    = eng_x[8*m_g +: 8];
    e_y    = eng_y[7*m_g +: 7];
    e_c    = eng_colour[3*m_g +: 3];
    e_plot = (m_phase == 1) && eng_plot[m_g];
    e_ack  = '0;
    e_err  = '0;
    if (m_phase == 0) begin
      w = -1;
      for (int k = 1; k <= NREQ; k++)
        if (w < 0 && req[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
      if (w >= 0) begin
        m_phase = 1; m_g = w; m_last = w; m_run = 0;
        e_start = '0; e_start[w] = 1'b1;
        grants_seen++;
      end
    end else if (m_phase == 1) begin
      if (eng_done[m_g]) begin
        m_phase = 2; e_start = '0; e_ack[m_g] = 1'b1;
      end else if (m_run == TO - 1) begin
        m_phase = 2; e_start = '0; e_ack[m_g] = 1'b1; e_err[m_g] = 1'b1;
        timeouts_seen++;
      end else begin
        m_run++;
      end
    end else begin
      if (!eng_done[m_g]) m_phase = 0;
    end
  endtask

  task automatic check_outputs();
    check("eng_start", eng_start, e_start);
    check("ack", ack, e_ack);
    check("err", err, e_err);
    check("vga_x", vga_x, e_x);
    check("vga_y", vga_y, e_y);
    check("vga_colour", vga_colour, e_c);
    check("vga_plot", vga_plot, e_plot);
    check("busy", busy, (m_phase != 0) ? 1 : 0);
    check("grant_id", grant_id, m_g);
  endtask

  initial begin
    logic [NREQ-1:0] noise;
    grants_seen = 0;
    timeouts_seen = 0;
    rst = 1'b1; req = '0; eng_done = '0; eng_plot = '0;
    eng_x = '0; eng_y = '0; eng_colour = '0; edone = '0;
    for (int i = 0; i < NREQ; i++) begin ecnt[i] = 0; lat[i] = 1; hold[i] = 0; end
    model_step();
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk); #1;
      check_outputs();
      // engines react to their start line
      for (int i = 0; i < NREQ; i++) begin
        if (eng_start[i]) begin
          if (ecnt[i] == 0) begin
            lat[i]  = $urandom_range(1, 20);
            hold[i] = $urandom_range(0, 2);
          end
          ecnt[i]++;
          if (ecnt[i] >= lat[i]) edone[i] = 1'b1;
        end else begin
          ecnt[i] = 0;
          if (edone[i]) begin
            if (hold[i] > 0) hold[i]--;
            else edone[i] = 1'b0;
          end
        end
      end
      // requesters drop after ack (mostly) and raise new jobs at random
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i] && $urandom_range(0, 7) != 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
      end
      // spurious done on engines other than the granted one
      noise = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++)
        if (i == m_g || $urandom_range(0, 7) != 0) noise[i] = 1'b0;
      eng_done   = edone | noise;
      eng_x      = 24'($urandom);
      eng_y      = 21'($urandom);
      eng_colour = 9'($urandom);
      eng_plot   = NREQ'($urandom);
      rst = (c < 2) || ($urandom_range(0, 399) == 0);
      if (c == 2) req = '1;
      model_step();
    end
    check("some_grants", (grants_seen > 20) ? 1 : 0, 1);
    check("some_timeouts", (timeouts_seen > 0) ? 1 : 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
